// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier, one adder, fixed WIDTH-cycle run.
// Result is (left * right) truncated to WIDTH bits; done pulses for one cycle.
module seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy
);

  // Counter must hold WIDTH itself, so it never wraps inside an operation.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] sum;
  logic             last_iter;

  // The single adder: accumulator plus the gated, shifted multiplicand.
  always_comb begin
    sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath control; everything holds unless told otherwise.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          mcand_d  = left;
          mplier_d = right;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        // go is deliberately ignored here; operands in flight are untouched.
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          // out only changes on entry to DONE, taking the final sum directly.
          out_d   = sum;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchronous reset wins over any go in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs come straight from flops / decoded state, no input-to-output path.
  assign out  = out_q;
  assign done = (state_q == DONE);
  assign busy = (state_q == RUN);

endmodule
